fp_convert_pipe: RTL and testbench
==================================

Name: fp_convert_pipe

Overview:
- Multi-channel, pipelined fixed-point format converter for streaming datapaths.
- Converts NCH lanes of one signed/unsigned Q-format into another signed/unsigned Q-format.
- Selectable rounding (truncate, round-half-up, convergent) and overflow handling (wrap or clip).
- Valid/ready handshake with backpressure, per-channel sticky overflow flags and a saturating overflow-beat counter.
- Sits between arithmetic blocks and register/DAC interfaces where the combinational converters are too coarse: they have no rounding, no pipelining and no flow control.

Parameters:
- NCH, 4, number of parallel lanes (>=1)
- IN_SIGNED, 1, 1 = input is sfp (IN_IW includes sign bit), 0 = ufp
- IN_IW, 4, input integer width
- IN_QW, 4, input fraction width
- OUT_SIGNED, 1, 1 = output is sfp (OUT_IW includes sign bit), 0 = ufp
- OUT_IW, 3, output integer width
- OUT_QW, 2, output fraction width
- RND_MODE, 1, 0 = truncate (floor), 1 = round half up, 2 = round half to even; ignored when OUT_QW >= IN_QW
- CLIP, 1, 1 = saturate on overflow, 0 = wrap (keep LSBs)
- CNT_W, 16, overflow counter width

Ports:
- clk, input, 1, clock
- rst_n, input, 1, asynchronous active-low reset
- in_valid, input, 1, input beat valid
- in_ready, output, 1, block can accept a beat
- in_data, input, NCH*(IN_IW+IN_QW), packed lanes; lane k at bits [k*WI +: WI]
- out_valid, output, 1, output beat valid
- out_ready, input, 1, downstream accepts beat
- out_data, output, NCH*(OUT_IW+OUT_QW), packed converted lanes; lane k at bits [k*WO +: WO]
- out_ovf, output, NCH, per-lane overflow flag for the current out_data beat
- sticky_ovf, output, NCH, per-lane sticky overflow flag
- ovf_cnt, output, CNT_W, number of accepted output beats with any lane overflowing, saturating
- clr_flags, input, 1, synchronous clear of sticky_ovf and ovf_cnt

Behaviour:
- Widths: WI = IN_IW+IN_QW, WO = OUT_IW+OUT_QW.
- Elaboration $error conditions:
  - WI < 1 or WO < 1.
  - RND_MODE > 2.
  - OUT_SIGNED = 1 with OUT_IW < 1.
- Reset (rst_n low, async):
  - out_valid, out_ovf, sticky_ovf, ovf_cnt all 0.
  - out_data is 0.
  - Pipeline holds no beats.
  - in_ready is 1 one cycle after rst_n deasserts.
- Pipeline:
  - Two register stages, S1 (align/round) and S2 (range reduce).
  - Latency is 2 cycles from input handshake to out_valid with no backpressure.
  - Full throughput: one beat per cycle.
- Handshake:
  - Transfer occurs when valid && ready.
  - A stage advances when it is empty or the next stage advances.
  - in_ready = !S1 full || S2 advances.
  - While out_valid && !out_ready, out_data and out_ovf hold stable.
  - No combinational path from in_valid to out_valid is permitted.
  - A combinational path from out_ready to in_ready is permitted.
- S1, per lane:
  - Sign-extend or zero-extend the input to an intermediate width with one guard integer bit.
  - If OUT_QW >= IN_QW: shift left by OUT_QW-IN_QW; no rounding.
  - Else drop D = IN_QW-OUT_QW LSBs:
    - RND 0: arithmetic floor.
    - RND 1: add 2^(D-1), then floor.
    - RND 2: as RND 1, except exactly-half ties go to the even result.
  - Rounding carry never wraps in S1.
- S2, per lane:
  - Compare the S1 value against the output range [min, max].
  - sfp range: min = -2^(WO-1), max = 2^(WO-1)-1. ufp range: min = 0, max = 2^WO-1.
  - Out of range sets out_ovf[k]=1 regardless of CLIP.
  - CLIP=1: output saturates to min or max.
  - CLIP=0: output takes the WO LSBs.
  - A negative value into ufp is out of range (clips to 0 when CLIP=1).
- Statistics (updated only on output handshake):
  - sticky_ovf[k] |= out_ovf[k].
  - ovf_cnt increments if |out_ovf and stops at 2^CNT_W-1.
  - clr_flags in the same cycle as an overflowing handshake: clear takes effect, then the event is applied. Result: affected flags = 1, ovf_cnt = 1.
- Reset mid-stream: in-flight beats are discarded; no output beat is produced for them.

Test Plan:
- Defaults (4.4 sfp -> 3.2 sfp, RND 1, CLIP 1), lane 0 in_data=0x13 (1.1875) -> out 0x05 (1.25) after 2 cycles, out_ovf=0; with RND 0 -> 0x04.
- Tie handling: 0x1A (1.625) -> RND 1 gives 0x07, RND 2 gives 0x06; 0x16 (1.375) -> RND 2 gives 0x06 (tie rounds up to even).
- Overflow: 0x7F -> CLIP 1 gives 0x0F with out_ovf=1; CLIP 0 gives 0x00 with out_ovf=1. 0x80 (-8) -> CLIP 1 gives 0x10 (-4).
- ufp output (OUT_SIGNED 0, OUT_IW 2): input 0xF0 (-1.0) -> 0x00 with ovf=1; 0x30 (3.0) -> 0x0C with ovf=0.
- Backpressure: stream 8 beats with out_ready toggling 1/0 each cycle -> all 8 beats delivered in order, none duplicated or dropped, out_data stable while stalled, in_ready low only when both stages are full.
- Statistics: CNT_W=2, 5 overflowing beats -> ovf_cnt=3 (saturated); clr_flags coincident with an overflowing beat -> ovf_cnt=1; assert rst_n low mid-stream -> all outputs 0 and pipeline empty.

Source files
------------

// File: rtl/fp_convert_pipe.sv
// rtl/fp_convert_pipe.sv - pipelined multi-lane fixed-point format converter
// S1 aligns/rounds each lane, S2 range-reduces (clip or wrap) and flags overflow.
module fp_convert_pipe #(
    parameter int NCH        = 4,
    parameter int IN_SIGNED  = 1,
    parameter int IN_IW      = 4,
    parameter int IN_QW      = 4,
    parameter int OUT_SIGNED = 1,
    parameter int OUT_IW     = 3,
    parameter int OUT_QW     = 2,
    parameter int RND_MODE   = 1,
    parameter int CLIP       = 1,
    parameter int CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NCH*(IN_IW+IN_QW)-1:0]     in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NCH*(OUT_IW+OUT_QW)-1:0]   out_data,
    output logic [NCH-1:0]                   out_ovf,
    output logic [NCH-1:0]                   sticky_ovf,
    output logic [CNT_W-1:0]                 ovf_cnt,
    input  logic                             clr_flags
);
    localparam int WI = IN_IW + IN_QW;
    localparam int WO = OUT_IW + OUT_QW;
    localparam int SH = (OUT_QW >= IN_QW) ? OUT_QW - IN_QW : 0;
    localparam int D  = (IN_QW > OUT_QW) ? IN_QW - OUT_QW : 0;
    // Two extra integer bits: one so ufp inputs stay non-negative, one for the rounding carry.
    localparam int WX = WI + 2;
    localparam int WS = WX + SH;
    localparam int WC = ((WS > WO + 1) ? WS : WO + 1) + 1;

    localparam logic signed [WC-1:0] ONE  = 1;
    localparam logic signed [WC-1:0] VMAX = (OUT_SIGNED != 0) ? (ONE <<< (WO - 1)) - ONE
                                                              : (ONE <<< WO) - ONE;
    localparam logic signed [WC-1:0] VMIN = (OUT_SIGNED != 0) ? -(ONE <<< (WO - 1)) : '0;

    if (WI < 1 || WO < 1) begin : g_err_width
        $error("fp_convert_pipe: input and output widths must be at least 1");
    end
    if (RND_MODE > 2) begin : g_err_rnd
        $error("fp_convert_pipe: RND_MODE must be 0, 1 or 2");
    end
    if (OUT_SIGNED == 1 && OUT_IW < 1) begin : g_err_sign
        $error("fp_convert_pipe: signed output needs OUT_IW >= 1");
    end

    logic [NCH*WS-1:0] s1_d;
    logic [NCH*WS-1:0] s1_q;
    logic [NCH*WO-1:0] s2_d;
    logic [NCH-1:0]    s2_ovf;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        logic [WI-1:0]        raw;
        logic signed [WX-1:0] ext;
        logic signed [WS-1:0] aligned;
        logic signed [WS-1:0] s1v;
        logic signed [WC-1:0] v;
        logic                 hi;
        logic                 lo;

        assign raw = in_data[k*WI +: WI];
        assign ext = (IN_SIGNED != 0) ? $signed({{2{raw[WI-1]}}, raw}) : $signed({2'b00, raw});

        if (D == 0) begin : g_align
            assign aligned = WS'(ext) <<< SH;
        end else begin : g_round
            localparam logic [WX-1:0] HALF = WX'(1) << (D - 1);
            logic signed [WX-1:0] up;
            logic                 tie;

            assign up  = (ext + $signed(HALF)) >>> D;
            assign tie = (ext[D-1:0] == HALF[D-1:0]);

            if (RND_MODE == 0) begin : g_trunc
                assign aligned = ext >>> D;
            end else if (RND_MODE == 1) begin : g_half_up
                assign aligned = up;
            end else begin : g_even
                // On an exact tie the rounded-up result is odd or even; clearing bit 0 picks the even neighbour.
                assign aligned = tie ? $signed({up[WX-1:1], 1'b0}) : up;
            end
        end

        assign s1_d[k*WS +: WS] = aligned;

        assign s1v       = s1_q[k*WS +: WS];
        assign v         = WC'(s1v);
        assign hi        = v > VMAX;
        assign lo        = v < VMIN;
        assign s2_ovf[k] = hi | lo;
        assign s2_d[k*WO +: WO] = (CLIP != 0 && hi) ? VMAX[WO-1:0] :
                                  (CLIP != 0 && lo) ? VMIN[WO-1:0] : v[WO-1:0];
    end

    logic             s1_full;
    logic             rdy_en;
    logic             s1_adv;
    logic             s2_adv;
    logic             in_fire;
    logic             out_fire;
    logic             ovf_evt;
    logic [NCH-1:0]   sticky_nxt;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_nxt;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_full || s2_adv;
    assign in_ready = rdy_en && s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign ovf_evt  = out_fire && (|out_ovf);

    // A clear in the same cycle as an overflowing beat wipes old state first, then records the beat.
    assign sticky_nxt = (clr_flags ? '0 : sticky_ovf) | (out_fire ? out_ovf : '0);
    assign cnt_base   = clr_flags ? '0 : ovf_cnt;
    assign cnt_nxt    = (ovf_evt && cnt_base != '1) ? cnt_base + CNT_W'(1) : cnt_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en     <= 1'b0;
            s1_full    <= 1'b0;
            s1_q       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ovf    <= '0;
            sticky_ovf <= '0;
            ovf_cnt    <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (s1_adv) begin
                s1_full <= in_fire;
                if (in_fire) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_full;
                out_ovf   <= s1_full ? s2_ovf : '0;
                if (s1_full) begin
                    out_data <= s2_d;
                end
            end
            sticky_ovf <= sticky_nxt;
            ovf_cnt    <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_fp_convert_pipe.sv
// tb/tb_fp_convert_pipe.sv - self-checking bench for fp_convert_pipe
// Four converter variants share one stimulus stream; a real-arithmetic model predicts every lane.
module tb_fp_convert_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        clr_flags;
    logic [31:0] in_data;

    logic [19:0] od  [4];
    logic [3:0]  ov  [4];
    logic [3:0]  st  [4];
    logic [15:0] cn  [4];
    logic        vld [4];
    logic        rdy [4];
    logic [15:0] od3;
    logic [1:0]  cn1;

    assign od[3] = {4'b0, od3};
    assign cn[1] = {14'b0, cn1};

    // variant:        u0  u1  u2  u3
    localparam int C_RND  [4] = '{1, 1, 0, 2};
    localparam int C_CLIP [4] = '{1, 0, 1, 1};
    localparam int C_OSG  [4] = '{1, 1, 1, 0};
    localparam int C_OIW  [4] = '{3, 3, 3, 2};
    localparam int C_CNTW [4] = '{16, 2, 16, 16};

    fp_convert_pipe u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .out_valid(vld[0]), .out_ready(out_ready), .out_data(od[0]), .out_ovf(ov[0]),
        .sticky_ovf(st[0]), .ovf_cnt(cn[0]), .clr_flags(clr_flags)
    );
    fp_convert_pipe #(.CLIP(0), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
        .out_valid(vld[1]), .out_ready(out_ready), .out_data(od[1]), .out_ovf(ov[1]),
        .sticky_ovf(st[1]), .ovf_cnt(cn1), .clr_flags(clr_flags)
    );
    fp_convert_pipe #(.RND_MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
        .out_valid(vld[2]), .out_ready(out_ready), .out_data(od[2]), .out_ovf(ov[2]),
        .sticky_ovf(st[2]), .ovf_cnt(cn[2]), .clr_flags(clr_flags)
    );
    fp_convert_pipe #(.RND_MODE(2), .OUT_SIGNED(0), .OUT_IW(2)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]), .in_data(in_data),
        .out_valid(vld[3]), .out_ready(out_ready), .out_data(od3), .out_ovf(ov[3]),
        .sticky_ovf(st[3]), .ovf_cnt(cn[3]), .clr_flags(clr_flags)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns {ovf, data}: scale 4.4 value by 2^(OUT_QW-IN_QW), round, then range-reduce.
    function automatic int lane_model(input logic [7:0] raw, input int ci);
        int  sv, ri, lo, hi, m, d, wo;
        real y, f, r;
        bit  ovf;
        wo = C_OIW[ci] + 2;
        sv = $signed(raw);
        y  = $itor(sv) / 4.0;
        f  = $floor(y);
        case (C_RND[ci])
            0:       r = f;
            1:       r = $floor(y + 0.5);
            default: r = (y - f == 0.5) ? (($rtoi(f) % 2 == 0) ? f : f + 1.0) : $floor(y + 0.5);
        endcase
        ri = $rtoi(r);
        m  = 1 << wo;
        if (C_OSG[ci] != 0) begin
            lo = -(m / 2);
            hi = m / 2 - 1;
        end else begin
            lo = 0;
            hi = m - 1;
        end
        ovf = (ri < lo) || (ri > hi);
        if (C_CLIP[ci] != 0 && ri > hi) ri = hi;
        else if (C_CLIP[ci] != 0 && ri < lo) ri = lo;
        d = ((ri % m) + m) % m;
        return (int'(ovf) << 8) | d;
    endfunction

    function automatic void beat_model(input logic [31:0] beat, input int ci,
                                       output logic [19:0] ed, output logic [3:0] eo);
        int r, wo;
        wo = C_OIW[ci] + 2;
        ed = '0;
        eo = '0;
        for (int k = 0; k < 4; k++) begin
            r     = lane_model(beat[k*8 +: 8], ci);
            ed    = ed | (20'(r & 'hFF) << (k * wo));
            eo[k] = r[8];
        end
    endfunction

    logic [31:0] q [$];
    int          ecnt [4];
    logic [3:0]  est  [4];
    logic [19:0] pod  [4];
    logic [3:0]  pov  [4];
    int          hi_cnt = 0;
    int          n_out = 0;
    bit          stall_prev = 0;

    always @(negedge clk) begin
        logic [19:0] ed;
        logic [3:0]  eo;
        logic [31:0] b;
        bit          exp_rdy;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("u%0d_rst_valid", i), vld[i], 0);
                chk($sformatf("u%0d_rst_data", i), od[i], 0);
                chk($sformatf("u%0d_rst_ovf", i), ov[i], 0);
                chk($sformatf("u%0d_rst_sticky", i), st[i], 0);
                chk($sformatf("u%0d_rst_cnt", i), cn[i], 0);
                ecnt[i] = 0;
                est[i]  = '0;
            end
            q.delete();
            hi_cnt     = 0;
            stall_prev = 0;
        end else begin
            exp_rdy = (hi_cnt > 0) && !(q.size() == 2 && !out_ready);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("u%0d_in_ready", i), rdy[i], exp_rdy);
                chk($sformatf("u%0d_sticky", i), st[i], est[i]);
                chk($sformatf("u%0d_ovf_cnt", i), cn[i], ecnt[i]);
                if (i > 0) chk($sformatf("u%0d_valid_align", i), vld[i], vld[0]);
                if (stall_prev) begin
                    chk($sformatf("u%0d_hold_data", i), od[i], pod[i]);
                    chk($sformatf("u%0d_hold_ovf", i), ov[i], pov[i]);
                end
            end
            if (clr_flags) begin
                for (int i = 0; i < 4; i++) begin
                    ecnt[i] = 0;
                    est[i]  = '0;
                end
            end
            if (vld[0] && out_ready) begin
                chk("beat_outstanding", q.size() > 0, 1);
                if (q.size() > 0) begin
                    b = q.pop_front();
                    n_out++;
                    for (int i = 0; i < 4; i++) begin
                        beat_model(b, i, ed, eo);
                        chk($sformatf("u%0d_data", i), od[i], ed);
                        chk($sformatf("u%0d_ovf", i), ov[i], eo);
                        est[i] = est[i] | eo;
                        if (eo != 0 && ecnt[i] < (1 << C_CNTW[i]) - 1) ecnt[i]++;
                    end
                end
            end
            if (in_valid && rdy[0]) q.push_back(in_data);
            stall_prev = vld[0] && !out_ready;
            for (int i = 0; i < 4; i++) begin
                pod[i] = od[i];
                pov[i] = ov[i];
            end
            hi_cnt++;
        end
    end

    logic [31:0] beats [8];

    task automatic send_one(input logic [31:0] d);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!vld[0] && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 2);
    endtask

    task automatic stream(input int n, input bit toggle);
        int i, cyc;
        bit acc;
        i   = 0;
        cyc = 0;
        while (i < n && cyc < 500) begin
            in_valid = 1'b1;
            in_data  = beats[i];
            @(negedge clk);
            acc = rdy[0];
            @(posedge clk); #1;
            if (acc) i++;
            if (toggle) out_ready = !out_ready;
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_sent", i, n);
    endtask

    task automatic drain(input bit toggle);
        int cyc;
        cyc = 0;
        while ((q.size() > 0 || vld[0]) && cyc < 100) begin
            @(posedge clk); #1;
            if (toggle) out_ready = !out_ready;
            cyc++;
        end
        out_ready = 1'b1;
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int nb, cyc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        clr_flags = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cnt_u0", cn[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_first_cycle", rdy[0], 0);
        @(negedge clk);
        chk("ready_second_cycle", rdy[0], 1);

        // lanes: 0x13, 0x1A, 0x16, 0x30
        send_one(32'h30161A13);
        chk("u0_l0_rnd1", od[0][4:0], 5'h05);
        chk("u0_l0_ovf", ov[0][0], 0);
        chk("u2_l0_rnd0", od[2][4:0], 5'h04);
        chk("u0_l1_rnd1_tie", od[0][9:5], 5'h07);
        chk("u3_l1_rnd2_tie", od[3][7:4], 4'h6);
        chk("u3_l2_rnd2_tie", od[3][11:8], 4'h6);
        chk("u3_l3_ufp", od[3][15:12], 4'hC);
        chk("u3_ovf_none", ov[3], 4'h0);

        // lanes: 0x7F, 0x80, 0xF0, 0x30
        send_one(32'h30F0807F);
        chk("u0_l0_clip", od[0][4:0], 5'h0F);
        chk("u0_l0_clip_ovf", ov[0][0], 1);
        chk("u1_l0_wrap", od[1][4:0], 5'h00);
        chk("u1_l0_wrap_ovf", ov[1][0], 1);
        chk("u0_l1_clip_min", od[0][9:5], 5'h10);
        chk("u3_l2_neg_ufp", od[3][11:8], 4'h0);
        chk("u3_ovf_lanes", ov[3], 4'b0111);
        drain(1'b0);

        beats[0] = 32'h30F0807F; beats[1] = 32'h13131313;
        beats[2] = 32'h1A161A16; beats[3] = 32'h7F7F0000;
        beats[4] = 32'h80808080; beats[5] = 32'hF0F00101;
        beats[6] = 32'h0F0E0D0C; beats[7] = 32'h2A3B4C5D;
        nb = n_out;
        @(posedge clk); #1;
        stream(8, 1'b1);
        drain(1'b1);
        chk("bp_delivered", n_out - nb, 8);

        @(posedge clk); #1;
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        for (int i = 0; i < 5; i++) beats[i] = 32'h0000007F;
        stream(5, 1'b0);
        drain(1'b0);
        chk("u1_cnt_saturated", cn[1], 3);
        chk("u0_cnt_five", cn[0], 5);
        chk("u0_sticky_lane0", st[0], 4'b0001);

        out_ready = 1'b0;
        beats[0] = 32'h7F7F7F7F;
        stream(1, 1'b0);
        cyc = 0;
        while (!vld[0] && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("stall_valid", vld[0], 1);
        @(posedge clk); #1;
        clr_flags = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        chk("clr_evt_u0_cnt", cn[0], 1);
        chk("clr_evt_u1_cnt", cn[1], 1);
        chk("clr_evt_u0_sticky", st[0], 4'hF);
        drain(1'b0);

        in_valid = 1'b1;
        in_data  = 32'h01020304;
        @(posedge clk); #1;
        in_data  = 32'h7F7F7F7F;
        @(posedge clk); #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_valid", vld[0], 0);
        chk("midrst_cnt", cn[0], 0);
        chk("midrst_sticky", st[0], 0);
        chk("midrst_data", od[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nb = n_out;
        repeat (6) @(negedge clk);
        chk("midrst_no_output", n_out - nb, 0);

        send_one(32'h13131313);
        chk("recover_u0", od[0], 20'h294A5);
        drain(1'b0);
        chk("final_queue", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
